// File: rtl/lcd_vram_fetch_if.sv
// VRAM read port and pixel byte stream between the LCD fetcher and its neighbours.
interface lcd_vram_fetch_if #(
  parameter int unsigned AW = 13
);
  logic          ram_gnt;
  logic          ram_ce;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_do;
  logic [7:0]    pix_data;
  logic          pix_valid;
  logic          pix_ready;
  logic          pix_eol;
  logic          pix_eof;

  modport master (
    output ram_ce, ram_addr, pix_data, pix_valid, pix_eol, pix_eof,
    input  ram_gnt, ram_do, pix_ready
  );

  modport slave (
    input  ram_ce, ram_addr, pix_data, pix_valid, pix_eol, pix_eof,
    output ram_gnt, ram_do, pix_ready
  );
endinterface

// File: rtl/lcd_vram_fetch.sv
// Frame walker reading VRAM line by line into a small FWFT FIFO with eol/eof tags.
// Optional abort input is enabled by defining LCD_FETCH_ABORT_EN.
module lcd_vram_fetch #(
  parameter int unsigned AW       = 13,
  parameter int unsigned MEM_SIZE = 6144,
  parameter int unsigned FDEPTH   = 4
) (
  input  logic           clk,
  input  logic           rst_x,
`ifdef LCD_FETCH_ABORT_EN
  input  logic           abort,
`endif
  input  logic           start,
  input  logic [AW-1:0]  sad,
  input  logic [7:0]     cr,
  input  logic [7:0]     ap,
  input  logic [7:0]     lines,
  lcd_vram_fetch_if.master bus,
  output logic           busy,
  output logic           done
);
  localparam int unsigned PW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;
  state_e state_q, state_d;

  logic [7:0]    cr_q, ap_q, lines_q, col_q, line_q;
  logic [AW-1:0] base_q, addr_q, base_next, addr_inc;
  logic [AW:0]   base_sum;
  logic          infl_q, infl_eol_q, infl_eof_q;
  logic [9:0]    mem [FDEPTH];
  logic [9:0]    head;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          kill, issue, push, pop, fifo_empty, is_eol, is_eof;

`ifdef LCD_FETCH_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  assign base_sum  = {1'b0, base_q} + {{(AW-7){1'b0}}, ap_q};
  assign base_next = (base_sum >= (AW+1)'(MEM_SIZE)) ? AW'(base_sum - (AW+1)'(MEM_SIZE))
                                                     : base_sum[AW-1:0];
  assign addr_inc  = (addr_q == AW'(MEM_SIZE - 1)) ? '0 : addr_q + AW'(1);
  assign is_eol    = (col_q == cr_q);
  assign is_eof    = is_eol && (line_q == lines_q);

  assign fifo_empty = (count_q == '0);
  assign head       = mem[rd_ptr_q];
  assign push       = infl_q;
  assign pop        = !fifo_empty && bus.pix_ready;
  assign issue      = bus.ram_ce;

  // Outputs read as zero while the FIFO is empty so stale entries never leak out.
  assign bus.pix_valid = !fifo_empty;
  assign bus.pix_data  = fifo_empty ? 8'h00 : head[7:0];
  assign bus.pix_eol   = !fifo_empty && head[8];
  assign bus.pix_eof   = !fifo_empty && head[9];
  assign bus.ram_addr  = addr_q;

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StFetch;
      StFetch: if (issue && is_eof) state_d = StDrain;
      StDrain: if (done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (kill) state_d = StIdle;
  end

  always_comb begin
    bus.ram_ce = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      StFetch: begin
        busy       = 1'b1;
        bus.ram_ce = bus.ram_gnt && ((count_q + CW'(infl_q)) < CW'(FDEPTH));
      end
      StDrain: begin
        done = pop && head[9] && !kill;
        busy = !done;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      cr_q       <= '0;
      ap_q       <= '0;
      lines_q    <= '0;
      col_q      <= '0;
      line_q     <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      infl_q     <= 1'b0;
      infl_eol_q <= 1'b0;
      infl_eof_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else if (kill) begin
      infl_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (state_q == StIdle && start) begin
        cr_q    <= cr;
        ap_q    <= ap;
        lines_q <= lines;
        base_q  <= sad;
        addr_q  <= sad;
        col_q   <= '0;
        line_q  <= '0;
      end else if (issue) begin
        if (is_eol) begin
          col_q  <= '0;
          line_q <= line_q + 8'd1;
          base_q <= base_next;
          addr_q <= base_next;
        end else begin
          col_q  <= col_q + 8'd1;
          addr_q <= addr_inc;
        end
      end
      infl_q     <= issue;
      infl_eol_q <= is_eol;
      infl_eof_q <= is_eof;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {infl_eof_q, infl_eol_q, bus.ram_do};
  end
endmodule

// File: tb/tb_lcd_vram_fetch.sv
// Directed, table-driven bench for lcd_vram_fetch with a behavioural 1-cycle VRAM.
module tb_lcd_vram_fetch;
  localparam int unsigned AW = 13, MEM_SIZE = 6144, FDEPTH = 4;

  logic        clk = 1'b0, rst_x = 1'b0, start = 1'b0;
  logic [12:0] sad = '0;
  logic [7:0]  cr = '0, ap = '0, lines = '0;
  logic        busy, done;
`ifdef LCD_FETCH_ABORT_EN
  logic        abort = 1'b0;
`endif

  lcd_vram_fetch_if #(.AW(AW)) bus ();

  lcd_vram_fetch #(.AW(AW), .MEM_SIZE(MEM_SIZE), .FDEPTH(FDEPTH)) dut (
    .clk   (clk),
    .rst_x (rst_x),
`ifdef LCD_FETCH_ABORT_EN
    .abort (abort),
`endif
    .start (start),
    .sad   (sad),
    .cr    (cr),
    .ap    (ap),
    .lines (lines),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  logic [7:0] vram [MEM_SIZE];
  always @(posedge clk) if (bus.ram_ce) bus.ram_do <= vram[bus.ram_addr];

  typedef struct {
    logic [12:0] sad;
    logic [7:0]  cr, ap, lines;
    bit          tog;
    int          stall, restart, n;
    int          addr [8];
    logic [7:0]  eol, eof;
  } vec_t;
  vec_t v [8];

  int n_cmp = 0, n_bad = 0;
  logic [12:0] q_addr [$];
  logic [9:0]  q_pix [$];
  int done_cnt, ce_nogo, stall_ce, busy_done_bad;

  always @(negedge clk) if (rst_x) begin
    if (bus.ram_ce) begin
      q_addr.push_back(bus.ram_addr);
      if (!bus.ram_gnt) ce_nogo++;
      if (!bus.pix_ready) stall_ce++;
    end
    if (bus.pix_valid && bus.pix_ready) q_pix.push_back({bus.pix_eol, bus.pix_eof, bus.pix_data});
    if (done) begin
      done_cnt++;
      if (busy) busy_done_bad++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    q_addr.delete();
    q_pix.delete();
    done_cnt = 0; ce_nogo = 0; stall_ce = 0; busy_done_bad = 0;
  endtask

  task automatic start_frame(input vec_t t);
    @(posedge clk); #1;
    sad = t.sad; cr = t.cr; ap = t.ap; lines = t.lines; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input vec_t t, input string tag);
    int c;
    logic [9:0] p;
    clear_mon();
    bus.ram_gnt = 1'b1;
    bus.pix_ready = (t.stall > 0) ? 1'b0 : 1'b1;
    start_frame(t);
    for (c = 0; c < 300; c++) begin
      bus.ram_gnt   = t.tog ? c[0] : 1'b1;
      bus.pix_ready = (c < t.stall) ? 1'b0 : 1'b1;
      start = (c == t.restart);
      if (c == t.restart) sad = 13'd100;
      #1;
      if (!busy) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check({tag, " timeout"}, (c < 300) ? 1 : 0, 1);
    @(posedge clk); #1;
    bus.ram_gnt = 1'b1;
    bus.pix_ready = 1'b1;
    check({tag, " n_reads"}, q_addr.size(), t.n);
    check({tag, " n_bytes"}, q_pix.size(), t.n);
    for (int i = 0; i < t.n; i++) begin
      check($sformatf("%s addr%0d", tag, i), (i < q_addr.size()) ? 32'(q_addr[i]) : '1, t.addr[i]);
      p = (i < q_pix.size()) ? q_pix[i] : 10'h3ff;
      check($sformatf("%s data%0d", tag, i), p[7:0], vram[t.addr[i]]);
      check($sformatf("%s eol%0d", tag, i), p[9], t.eol[i]);
      check($sformatf("%s eof%0d", tag, i), p[8], t.eof[i]);
    end
    check({tag, " done_cnt"}, done_cnt, 1);
    check({tag, " busy_at_done"}, busy_done_bad, 0);
    check({tag, " ce_without_gnt"}, ce_nogo, 0);
    check({tag, " reads_while_stalled"}, stall_ce, (t.stall > 0) ? FDEPTH : 0);
    check({tag, " busy_after"}, busy, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " ram_ce"}, bus.ram_ce, 0);
    check({tag, " ram_addr"}, bus.ram_addr, 0);
    check({tag, " pix_valid"}, bus.pix_valid, 0);
    check({tag, " pix_data"}, bus.pix_data, 0);
    check({tag, " pix_eol"}, bus.pix_eol, 0);
    check({tag, " pix_eof"}, bus.pix_eof, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
  endtask

  initial begin
    for (int i = 0; i < MEM_SIZE; i++) vram[i] = 8'((i * 37 + 11) & 255);
    v[0] = '{13'd0, 8'd3, 8'd4, 8'd1, 1'b0, 0, -1, 8, '{0, 1, 2, 3, 4, 5, 6, 7}, 8'h88, 8'h80};
    v[1] = '{13'd6142, 8'd3, 8'd4, 8'd0, 1'b0, 0, -1, 4,
             '{6142, 6143, 0, 1, 0, 0, 0, 0}, 8'h08, 8'h08};
    v[2] = v[0]; v[2].stall = 20;
    v[3] = v[0]; v[3].tog = 1'b1;
    v[4] = '{13'd6140, 8'd0, 8'd5, 8'd2, 1'b0, 0, -1, 3, '{6140, 1, 6, 0, 0, 0, 0, 0}, 8'h07, 8'h04};
    v[5] = '{13'd10, 8'd1, 8'd0, 8'd2, 1'b0, 0, -1, 6,
             '{10, 11, 10, 11, 10, 11, 0, 0}, 8'h2A, 8'h20};
    v[6] = '{13'd6143, 8'd1, 8'd2, 8'd1, 1'b0, 0, -1, 4, '{6143, 0, 1, 2, 0, 0, 0, 0}, 8'h0A, 8'h08};
    v[7] = v[2]; v[7].restart = 5;

    bus.ram_gnt = 1'b1;
    bus.pix_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_x = 1'b1;

    for (int k = 0; k < 8; k++) run_frame(v[k], $sformatf("vec%0d", k));

    // Asynchronous reset in the middle of a back-pressured frame.
    bus.pix_ready = 1'b0;
    start_frame(v[0]);
    repeat (3) @(posedge clk);
    #1;
    check("midrst pre_valid", bus.pix_valid, 1);
    check("midrst pre_busy", busy, 1);
    rst_x = 1'b0;
    #1;
    check_idle_outputs("midrst");
    @(posedge clk); #1;
    rst_x = 1'b1;
    run_frame(v[0], "after_rst");

`ifdef LCD_FETCH_ABORT_EN
    clear_mon();
    bus.pix_ready = 1'b0;
    start_frame(v[0]);
    for (int c = 0; c < 4; c++) begin
      bus.ram_gnt = (c < 3);
      @(posedge clk); #1;
    end
    check("abort pre_valid", bus.pix_valid, 1);
    check("abort pre_reads", q_addr.size(), 3);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort pix_valid", bus.pix_valid, 0);
    check("abort busy", busy, 0);
    bus.ram_gnt = 1'b1;
    bus.pix_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("abort done_cnt", done_cnt, 0);
    check("abort stays_empty", bus.pix_valid, 0);
    check("abort no_reads", bus.ram_ce, 0);
    run_frame(v[0], "after_abort");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
